branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameters SHALL be: BHT_DEPTH, default 256, number of 2-bit counters (power of 2); BTB_DEPTH, default 64, number of target entries (power of 2); RAS_DEPTH, default 8, return-stack entries (power of 2).
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
REQ-003 Fetch-side ports SHALL be:
- if_pc  in  32  fetch PC to predict.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
REQ-004 Resolve-side ports SHALL be:
- ex_valid  in  1  resolved control-flow instruction present.
- ex_pc  in  32  its PC.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  j/jal/jr/jalr.
- ex_is_call  in  1  jal/jalr/bgezal/bltzal.
- ex_is_ret  in  1  jr $ra.
- ex_taken  in  1  actual outcome.
- ex_target  in  32  actual target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  32  prediction carried down the pipe.
REQ-005 Output ports SHALL be:
- mispredict  out  1  flush request.
- perf_branches  out  32  resolved-instruction count.
- perf_misses  out  32  mispredict count.

Function
REQ-006 BHT index SHALL be pc[log2(BHT_DEPTH)+1:2]; BTB index SHALL be pc[log2(BTB_DEPTH)+1:2]; BTB tag SHALL be the remaining upper PC bits.
REQ-007 Lookup SHALL be combinational from stored state, with zero-cycle latency.
REQ-008 pred_taken SHALL be 1 iff the BTB entry is valid, the tag matches, and (counter[1]==1 or the entry is a jump).
REQ-009 pred_target SHALL be the BTB target when pred_taken is 1, else if_pc+4 (32-bit wrap).
REQ-010 On a clock edge with ex_valid & (ex_is_branch|ex_is_jump), the counter at ex_pc SHALL update:
- taken: increment, saturating at 2'b11.
- not taken: decrement, saturating at 2'b00.
- jumps: set to 2'b11.
REQ-011 When ex_taken is 1, the BTB entry at ex_pc SHALL be written with valid=1, tag, ex_target, jump flag (ex_is_jump), and ret flag (ex_is_ret); not-taken branches SHALL leave the BTB unchanged.
REQ-012 A same-cycle lookup and update to the same index SHALL return the pre-update value (no bypass).
REQ-013 mispredict SHALL be combinational: ex_valid & ((ex_pred_taken!=ex_taken) | (ex_taken & ex_pred_target!=ex_target)).
REQ-014 perf_branches SHALL increment on every update edge, and perf_misses whenever mispredict is 1; both SHALL wrap modulo 2^32.
REQ-015 With ex_valid low, no state SHALL change.

Reset
REQ-016 While resetn is 0, all of the following SHALL hold asynchronously:
- BTB valid bits = 0.
- every counter = 2'b01 (weakly not-taken).
- RAS pointer and count = 0.
- perf counters = 0.
- pred_taken = 0 and pred_target = if_pc+4.
REQ-017 Reset asserted mid-update SHALL discard that update; the first update SHALL be accepted on the first rising edge after resetn deasserts.

Configuration
REQ-018 With BP_RAS_EN defined, a circular return stack SHALL be present with this behaviour:
- ex_is_call pushes ex_pc+8 (delay slot).
- ex_is_ret pops.
- on a lookup hit with the ret flag set and RAS non-empty, pred_target = RAS top.
REQ-019 RAS boundaries SHALL be:
- push when full overwrites the oldest entry; count saturates at RAS_DEPTH; pointer wraps.
- pop when empty is ignored, and prediction falls back to the BTB target.
- simultaneous push and pop replaces top, with the count unchanged.
REQ-020 Without BP_RAS_EN, there SHALL be no RAS storage, and ret entries SHALL predict the BTB target.

Structure
REQ-021 Counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the PC+8 link offset SHALL live in the shared defines header beside the branch opcode constants.
REQ-022 The RAS SHALL be a separate sub-module, bp_ras, instantiated only under BP_RAS_EN.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then if_pc=0xBFC00000 -> pred_taken=0, pred_target=0xBFC00004, perf counters 0.
- Three taken updates at ex_pc=0x80001000, target 0x80001040 -> counter 01->10->11->11; lookup then gives pred_taken=1, pred_target=0x80001040.
- Then two not-taken updates -> counter 11->10->01; pred_taken=0; BTB entry still valid.
- Aliasing: update 0x80001000, then look up 0x80011000 (same index, different tag) -> pred_taken=0.
- Mispredict: ex_pred_taken=1, ex_taken=1, ex_pred_target=0x100, ex_target=0x104 -> mispredict=1; perf_misses increments by 1.
- BP_RAS_EN with RAS_DEPTH=8: 9 calls from 0x1000,0x1010,... -> 8 pops return 0x1088 down to 0x1018; 9th pop ignored (falls back to BTB target); assert resetn mid-sequence -> count=0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared branch-predictor definitions: counter encodings, link offset and branch opcodes.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam logic [31:0] LINK_OFFSET = 32'd8;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    // Jumps pin the counter to strongly-taken; branches saturate in both directions.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken, input logic is_jump);
        ctr_e n;
        n = c;
        if (is_jump) begin
            n = CTR_ST;
        end else if (taken) begin
            if (c != CTR_ST) n = ctr_e'(c + 2'd1);
        end else begin
            if (c != CTR_SNT) n = ctr_e'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// Circular return-address stack; pushing when full overwrites the oldest entry.
module bp_ras
    import branch_predictor_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [31:0]   stack_q [DEPTH];
    logic [31:0]   stack_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, top_idx;
    logic [PW:0]   cnt_q, cnt_d;

    assign top_idx = ptr_q - PW'(1);
    assign top     = stack_q[top_idx];
    assign empty   = (cnt_q == '0);

    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (push && pop && !empty) begin
            stack_d[top_idx] = push_data;
        end else if (push) begin
            stack_d[ptr_q] = push_data;
            ptr_d          = ptr_q + PW'(1);
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal BHT + tagged BTB branch predictor; BP_RAS_EN adds a return-address stack.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 256,
    parameter int unsigned BTB_DEPTH = 64,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_is_call,
    input  logic        ex_is_ret,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_misses
);
    localparam int unsigned BHT_IW = $clog2(BHT_DEPTH);
    localparam int unsigned BTB_IW = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W  = 30 - BTB_IW;

    ctr_e             bht_q       [BHT_DEPTH];
    ctr_e             bht_d       [BHT_DEPTH];
    logic             btb_valid_q [BTB_DEPTH];
    logic             btb_valid_d [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag_q   [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag_d   [BTB_DEPTH];
    logic [31:0]      btb_tgt_q   [BTB_DEPTH];
    logic [31:0]      btb_tgt_d   [BTB_DEPTH];
    logic             btb_jmp_q   [BTB_DEPTH];
    logic             btb_jmp_d   [BTB_DEPTH];
    logic             btb_ret_q   [BTB_DEPTH];
    logic             btb_ret_d   [BTB_DEPTH];
    logic [31:0]      perf_branches_q, perf_branches_d;
    logic [31:0]      perf_misses_q, perf_misses_d;

    logic [BHT_IW-1:0] if_bht_idx, ex_bht_idx;
    logic [BTB_IW-1:0] if_btb_idx, ex_btb_idx;
    logic [TAG_W-1:0]  if_tag, ex_tag;
    logic [1:0]        if_ctr;
    logic              upd, btb_we, hit, use_ras;
    logic [31:0]       ras_top;
    logic              unused_ok;

    assign if_bht_idx = if_pc[BHT_IW+1:2];
    assign ex_bht_idx = ex_pc[BHT_IW+1:2];
    assign if_btb_idx = if_pc[BTB_IW+1:2];
    assign ex_btb_idx = ex_pc[BTB_IW+1:2];
    assign if_tag     = if_pc[31:BTB_IW+2];
    assign ex_tag     = ex_pc[31:BTB_IW+2];
    assign unused_ok  = ^{if_pc[1:0], ex_pc[1:0]};

    assign upd        = ex_valid & (ex_is_branch | ex_is_jump);
    assign btb_we     = upd & ex_taken;
    assign mispredict = ex_valid & ((ex_pred_taken != ex_taken) |
                                    (ex_taken & (ex_pred_target != ex_target)));
    assign perf_branches = perf_branches_q;
    assign perf_misses   = perf_misses_q;

`ifdef BP_RAS_EN
    logic ras_empty;

    bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .resetn    (resetn),
        .push      (ex_valid & ex_is_call),
        .pop       (ex_valid & ex_is_ret),
        .push_data (ex_pc + LINK_OFFSET),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    assign use_ras = btb_ret_q[if_btb_idx] & ~ras_empty;
`else
    logic unused_cfg;

    assign use_ras    = 1'b0;
    assign ras_top    = '0;
    assign unused_cfg = ^{ex_is_call, (RAS_DEPTH != 0)};
`endif

    // Lookup reads only registered state, so a same-cycle update is never bypassed.
    always_comb begin
        if_ctr     = bht_q[if_bht_idx];
        hit        = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
        pred_taken = hit && (if_ctr[1] || btb_jmp_q[if_btb_idx]);
        if (!pred_taken)  pred_target = if_pc + INSTR_BYTES;
        else if (use_ras) pred_target = ras_top;
        else              pred_target = btb_tgt_q[if_btb_idx];
    end

    always_comb begin
        bht_d           = bht_q;
        btb_valid_d     = btb_valid_q;
        btb_tag_d       = btb_tag_q;
        btb_tgt_d       = btb_tgt_q;
        btb_jmp_d       = btb_jmp_q;
        btb_ret_d       = btb_ret_q;
        perf_branches_d = perf_branches_q;
        perf_misses_d   = perf_misses_q;
        if (upd) begin
            bht_d[ex_bht_idx] = ctr_next(bht_q[ex_bht_idx], ex_taken, ex_is_jump);
            perf_branches_d   = perf_branches_q + 32'd1;
        end
        if (btb_we) begin
            btb_valid_d[ex_btb_idx] = 1'b1;
            btb_tag_d[ex_btb_idx]   = ex_tag;
            btb_tgt_d[ex_btb_idx]   = ex_target;
            btb_jmp_d[ex_btb_idx]   = ex_is_jump;
            btb_ret_d[ex_btb_idx]   = ex_is_ret;
        end
        if (mispredict) perf_misses_d = perf_misses_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_WNT;
            for (int unsigned i = 0; i < BTB_DEPTH; i++) btb_valid_q[i] <= 1'b0;
            perf_branches_q <= '0;
            perf_misses_q   <= '0;
        end else begin
            bht_q           <= bht_d;
            btb_valid_q     <= btb_valid_d;
            perf_branches_q <= perf_branches_d;
            perf_misses_q   <= perf_misses_d;
        end
    end

    // Entry payload is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
        btb_jmp_q <= btb_jmp_d;
        btb_ret_q <= btb_ret_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (RAS scenarios under BP_RAS_EN).
module tb_branch_predictor;

    localparam logic [31:0] PC_A    = 32'h8000_1000;
    localparam logic [31:0] TGT_A   = 32'h8000_1040;
    localparam logic [31:0] TGT_B   = 32'h8000_1080;
    localparam logic [31:0] PC_ALI  = 32'h8001_1000;
    localparam logic [31:0] PC_M    = 32'h8000_2010;
    localparam logic [31:0] PC_J    = 32'h8000_3020;
    localparam logic [31:0] TGT_J   = 32'h8000_4000;
    localparam logic [31:0] RET_PC  = 32'h8000_5004;
    localparam logic [31:0] RET_TGT = 32'h8000_6000;
    localparam logic [31:0] CALL_T  = 32'h8000_7000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_is_call, ex_is_ret, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] perf_branches, perf_misses;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_miss = 0;

    always #5 clk = ~clk;

    branch_predictor #(.BHT_DEPTH(256), .BTB_DEPTH(64), .RAS_DEPTH(8)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_is_call     (ex_is_call),
        .ex_is_ret      (ex_is_ret),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .perf_branches  (perf_branches),
        .perf_misses    (perf_misses)
    );

    task automatic clear_ex();
        ex_valid = 0; ex_pc = '0; ex_is_branch = 0; ex_is_jump = 0; ex_is_call = 0;
        ex_is_ret = 0; ex_taken = 0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic br, input logic jmp, input logic call,
                            input logic ret, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1; ex_pc = pc; ex_is_branch = br; ex_is_jump = jmp; ex_is_call = call;
        ex_is_ret = ret; ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Correctly-predicted update: no mispredict, one branch counted.
    task automatic update(input logic [31:0] pc, input logic br, input logic jmp, input logic call,
                          input logic ret, input logic tk, input logic [31:0] tgt);
        drive_ex(pc, br, jmp, call, ret, tk, tgt, tk, tgt);
        step();
        clear_ex();
        exp_br++;
    endtask

    task automatic test_reset();
        if_pc = 32'hBFC0_0000;
        #3;
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
        n_vec++; if (pred_target !== 32'hBFC0_0004) begin n_err++; $display("FAIL reset_pred_target: got %h want bfc00004", pred_target); end
        n_vec++; if (perf_branches !== 32'd0) begin n_err++; $display("FAIL reset_perf_branches: got %0d want 0", perf_branches); end
        n_vec++; if (perf_misses !== 32'd0) begin n_err++; $display("FAIL reset_perf_misses: got %0d want 0", perf_misses); end
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        step();
        n_vec++; if (pred_target !== 32'hBFC0_0004) begin n_err++; $display("FAIL post_reset_target: got %h want bfc00004", pred_target); end
    endtask

    task automatic test_counter();
        logic exp_tk [5];
        exp_tk = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        if_pc = PC_A;
        for (int i = 0; i < 5; i++) begin
            update(PC_A, 1, 0, 0, 0, (i < 3), TGT_A);
            n_vec++; if (pred_taken !== exp_tk[i]) begin n_err++; $display("FAIL ctr_pred_taken[%0d]: got %b want %b", i, pred_taken, exp_tk[i]); end
        end
        n_vec++; if (pred_target !== 32'h8000_1004) begin n_err++; $display("FAIL ctr_nt_target: got %h want 80001004", pred_target); end
        n_vec++; if (dut.btb_valid_q[0] !== 1'b1) begin n_err++; $display("FAIL ctr_btb_valid: got %b want 1", dut.btb_valid_q[0]); end
    endtask

    task automatic test_no_bypass();
        if_pc = PC_A;
        drive_ex(PC_A, 1, 0, 0, 0, 1, TGT_B, 1, TGT_B);
        #2;
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL bypass_pred_taken: got %b want 0", pred_taken); end
        n_vec++; if (pred_target !== 32'h8000_1004) begin n_err++; $display("FAIL bypass_pred_target: got %h want 80001004", pred_target); end
        step();
        clear_ex();
        exp_br++;
        n_vec++; if (pred_target !== TGT_B) begin n_err++; $display("FAIL after_update_target: got %h want %h", pred_target, TGT_B); end
    endtask

    task automatic test_alias();
        if_pc = PC_ALI;
        #1;
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_pred_taken: got %b want 0", pred_taken); end
        n_vec++; if (pred_target !== 32'h8001_1004) begin n_err++; $display("FAIL alias_pred_target: got %h want 80011004", pred_target); end
    endtask

    task automatic test_mispredict();
        drive_ex(PC_M, 1, 0, 0, 0, 1, 32'h104, 1, 32'h100);
        #2;
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL miss_target: got %b want 1", mispredict); end
        step();
        exp_br++; exp_miss++;
        n_vec++; if (perf_misses !== exp_miss) begin n_err++; $display("FAIL perf_misses_inc: got %0d want %0d", perf_misses, exp_miss); end
        n_vec++; if (perf_branches !== exp_br) begin n_err++; $display("FAIL perf_branches: got %0d want %0d", perf_branches, exp_br); end
        drive_ex(PC_M, 1, 0, 0, 0, 1, 32'h104, 1, 32'h104);
        #2;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL miss_correct: got %b want 0", mispredict); end
        step();
        exp_br++;
        drive_ex(PC_M, 1, 0, 0, 0, 0, 32'h104, 0, 32'h100);
        #2;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL miss_nt_target_ignored: got %b want 0", mispredict); end
        step();
        exp_br++;
        drive_ex(PC_M, 1, 0, 0, 0, 0, 32'h104, 1, 32'h104);
        #2;
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL miss_direction: got %b want 1", mispredict); end
        step();
        clear_ex();
        exp_br++; exp_miss++;
        n_vec++; if (perf_misses !== exp_miss) begin n_err++; $display("FAIL perf_misses_total: got %0d want %0d", perf_misses, exp_miss); end
    endtask

    task automatic test_jump();
        update(PC_J, 0, 1, 0, 0, 1, TGT_J);
        if_pc = PC_J;
        #1;
        n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL jump_pred_taken: got %b want 1", pred_taken); end
        n_vec++; if (pred_target !== TGT_J) begin n_err++; $display("FAIL jump_pred_target: got %h want %h", pred_target, TGT_J); end
    endtask

    task automatic test_hold();
        drive_ex(PC_A, 1, 0, 0, 0, 1, 32'h1234_5678, 0, 32'h0);
        ex_valid = 0;
        if_pc = PC_A;
        #2;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL hold_mispredict: got %b want 0", mispredict); end
        step();
        clear_ex();
        n_vec++; if (pred_target !== TGT_B) begin n_err++; $display("FAIL hold_target: got %h want %h", pred_target, TGT_B); end
        n_vec++; if (perf_branches !== exp_br) begin n_err++; $display("FAIL hold_perf_branches: got %0d want %0d", perf_branches, exp_br); end
    endtask

    task automatic test_wrap();
        if_pc = 32'hFFFF_FFFC;
        #1;
        n_vec++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_target: got %h want 00000000", pred_target); end
    endtask

    task automatic test_reset_mid();
        if_pc = PC_A;
        drive_ex(PC_J, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        #2 resetn = 1'b0;
        step();
        exp_br = 0; exp_miss = 0;
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rstmid_pred_taken: got %b want 0", pred_taken); end
        n_vec++; if (perf_branches !== 32'd0) begin n_err++; $display("FAIL rstmid_perf: got %0d want 0", perf_branches); end
        drive_ex(PC_A, 1, 0, 0, 0, 1, TGT_A, 1, TGT_A);
        @(negedge clk) resetn = 1'b1;
        step();
        clear_ex();
        exp_br++;
        n_vec++; if (perf_branches !== exp_br) begin n_err++; $display("FAIL first_update_count: got %0d want %0d", perf_branches, exp_br); end
        n_vec++; if (pred_target !== TGT_A) begin n_err++; $display("FAIL first_update_target: got %h want %h", pred_target, TGT_A); end
    endtask

`ifdef BP_RAS_EN
    task automatic test_ras();
        logic [31:0] exp_top;
        update(RET_PC, 0, 1, 0, 1, 1, RET_TGT);
        if_pc = RET_PC;
        #1;
        n_vec++; if (pred_target !== RET_TGT) begin n_err++; $display("FAIL ras_empty_fallback: got %h want %h", pred_target, RET_TGT); end
        for (int i = 0; i < 9; i++) update(32'h1000 + 32'(16 * i), 0, 1, 1, 0, 1, CALL_T);
        for (int k = 0; k < 8; k++) begin
            exp_top = 32'h1088 - 32'(16 * k);
            #1;
            n_vec++; if (pred_target !== exp_top) begin n_err++; $display("FAIL ras_pop[%0d]: got %h want %h", k, pred_target, exp_top); end
            update(RET_PC, 0, 1, 0, 1, 1, RET_TGT);
        end
        n_vec++; if (pred_target !== RET_TGT) begin n_err++; $display("FAIL ras_drained: got %h want %h", pred_target, RET_TGT); end
        update(RET_PC, 0, 1, 0, 1, 1, RET_TGT);
        n_vec++; if (pred_target !== RET_TGT) begin n_err++; $display("FAIL ras_pop_empty: got %h want %h", pred_target, RET_TGT); end
        update(32'h1000, 0, 1, 1, 0, 1, CALL_T);
        update(32'h1010, 0, 1, 1, 0, 1, CALL_T);
        #2 resetn = 1'b0;
        step();
        @(negedge clk) resetn = 1'b1;
        step();
        update(RET_PC, 0, 1, 0, 1, 1, RET_TGT);
        n_vec++; if (pred_target !== RET_TGT) begin n_err++; $display("FAIL ras_reset_count: got %h want %h", pred_target, RET_TGT); end
    endtask
`else
    task automatic test_ras();
        update(RET_PC, 0, 1, 0, 1, 1, RET_TGT);
        update(32'h1000, 0, 1, 1, 0, 1, CALL_T);
        if_pc = RET_PC;
        #1;
        n_vec++; if (pred_target !== RET_TGT) begin n_err++; $display("FAIL ret_btb_target: got %h want %h", pred_target, RET_TGT); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        clear_ex();
        test_reset();
        test_counter();
        test_no_bypass();
        test_alias();
        test_mispredict();
        test_jump();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_ras();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
